heat_column_store: RTL and testbench

//  Per-column pixel store downstream of the DPS read/plot controller; one instance per screen column (64 total).

---
 rtl/heatmap_pkg.sv | 28 ++
 rtl/column_ram.sv | 66 ++++++
 rtl/heat_column_store.sv | 164 ++++++++++++++++
 tb/tb_heat_column_store.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/heatmap_pkg.sv
// heatmap_pkg
//   Shared defaults and the write-controller state encoding for the
//   heat_column_store column slice.
//   Contents: default rows per column, row/pixel widths, clear-sweep colour,
//   and the state_t encoding used by heat_column_store.
//   Optional feature macro: COLUMN_CLEAR_EN (adds the CLEAR state and the
//   clear colour default).
package heatmap_pkg;

   localparam int HM_ROWS  = 480;
   localparam int HM_ROW_W = 10;
   localparam int HM_PIX_W = 8;

`ifdef COLUMN_CLEAR_EN
   localparam logic [7:0] HM_CLEAR_COLOR = 8'h00;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
`ifdef COLUMN_CLEAR_EN
      ,
      ST_CLEAR = 2'd3
`endif
   } state_t;

endpackage

// File: rtl/column_ram.sv
// column_ram
//   Simple dual-port column RAM, DEPTH x DATA_W, one write port and one read
//   port on the same clock. Read path has a registered address and a
//   registered data word (2-cycle latency). A read and write hitting the same
//   row on the same edge return the old contents.
//   Ports:
//     clock    in   system clock
//     reset    in   async active-high reset (read masking pipeline only)
//     wr_en    in   write strobe
//     wr_addr  in   write row
//     wr_data  in   write data
//     rd_addr  in   read row, sampled every cycle
//     rd_data  out  read data, 2 cycles after rd_addr; 0 for rows >= DEPTH
module column_ram
   import heatmap_pkg::*;
#(
   parameter int DEPTH  = HM_ROWS,
   parameter int ADDR_W = HM_ROW_W,
   parameter int DATA_W = HM_PIX_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int MEM_AW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [MEM_AW-1:0] rd_addr_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic              rd_oob_a_reg;
   logic              rd_oob_d_reg;
   logic              wr_ok;

   // Rows past DEPTH are never written, so the truncated index cannot alias
   // onto a real row.
   assign wr_ok = wr_en && (wr_addr <= LAST);

   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem[wr_addr[MEM_AW-1:0]] <= wr_data;
      end
      rd_addr_reg <= rd_addr[MEM_AW-1:0];
      rd_data_reg <= mem[rd_addr_reg];
   end

   // Out-of-range flag travels alongside the read so the data word can be
   // forced to zero. Reset to 1 so the output reads 0 until the pipeline refills.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_oob_a_reg <= 1'b1;
         rd_oob_d_reg <= 1'b1;
      end else begin
         rd_oob_a_reg <= (rd_addr > LAST);
         rd_oob_d_reg <= rd_oob_a_reg;
      end
   end

   assign rd_data = rd_oob_d_reg ? '0 : rd_data_reg;

endmodule

// File: rtl/heat_column_store.sv
// heat_column_store
//   One screen column of pixel storage. Accepts single-pixel writes over a
//   four-phase col_select/return_sig handshake and serves the VGA scan-out
//   from a fixed 2-cycle read port.
//   Ports:
//     clock        in   system clock
//     reset        in   async active-high reset
//     col_select   in   write request (level, four-phase)
//     row_select   in   target row, latched when the request is accepted
//     pixel_color  in   colour, latched with row_select
//     return_sig   out  write acknowledge (registered)
//     vga_row      in   scan-out read row
//     vga_pixel    out  scan-out data, 2 cycles after vga_row
//     row_err      out  sticky: a request targeted a row >= ROWS
//     clear_req    in   clear sweep start pulse (COLUMN_CLEAR_EN only)
//     clear_busy   out  high for the whole sweep (COLUMN_CLEAR_EN only)
//   Optional feature macro: COLUMN_CLEAR_EN.
module heat_column_store
   import heatmap_pkg::*;
#(
   parameter int ROWS  = HM_ROWS,
   parameter int ROW_W = HM_ROW_W,
   parameter int PIX_W = HM_PIX_W
`ifdef COLUMN_CLEAR_EN
   ,
   parameter logic [PIX_W-1:0] CLEAR_COLOR = PIX_W'(HM_CLEAR_COLOR)
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             col_select,
   input  logic [ROW_W-1:0] row_select,
   input  logic [PIX_W-1:0] pixel_color,
   output logic             return_sig,
   input  logic [ROW_W-1:0] vga_row,
   output logic [PIX_W-1:0] vga_pixel,
   output logic             row_err
`ifdef COLUMN_CLEAR_EN
   ,
   input  logic             clear_req,
   output logic             clear_busy
`endif
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   state_t           state_reg, state_next;
   logic [ROW_W-1:0] wr_row_reg, wr_row_next;
   logic [PIX_W-1:0] wr_pix_reg, wr_pix_next;
   logic             return_reg;
   logic             row_err_reg, row_err_next;
   logic             ram_we;
   logic [ROW_W-1:0] ram_waddr;
   logic [PIX_W-1:0] ram_wdata;

`ifdef COLUMN_CLEAR_EN
   logic [ROW_W-1:0] clear_cnt_reg, clear_cnt_next;
   logic             busy_reg;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         wr_row_reg    <= '0;
         wr_pix_reg    <= '0;
         return_reg    <= 1'b0;
         row_err_reg   <= 1'b0;
`ifdef COLUMN_CLEAR_EN
         clear_cnt_reg <= '0;
         busy_reg      <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         wr_row_reg    <= wr_row_next;
         wr_pix_reg    <= wr_pix_next;
         // Outputs registered from the next state so they change on the
         // same edge as the state itself.
         return_reg    <= (state_next == ST_ACK);
         row_err_reg   <= row_err_next;
`ifdef COLUMN_CLEAR_EN
         clear_cnt_reg <= clear_cnt_next;
         busy_reg      <= (state_next == ST_CLEAR);
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      wr_row_next    = wr_row_reg;
      wr_pix_next    = wr_pix_reg;
      row_err_next   = row_err_reg;
      ram_we         = 1'b0;
      ram_waddr      = wr_row_reg;
      ram_wdata      = wr_pix_reg;
`ifdef COLUMN_CLEAR_EN
      clear_cnt_next = clear_cnt_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
`ifdef COLUMN_CLEAR_EN
            // A clear arriving with a request takes priority; the request
            // stays pending on col_select and is served after the sweep.
            if (clear_req) begin
               state_next     = ST_CLEAR;
               clear_cnt_next = '0;
            end else
`endif
            if (col_select) begin
               state_next  = ST_WRITE;
               wr_row_next = row_select;
               wr_pix_next = pixel_color;
            end
         end
         ST_WRITE: begin
            if (wr_row_reg > LAST_ROW) begin
               row_err_next = 1'b1;
            end else begin
               ram_we = 1'b1;
            end
            state_next = ST_ACK;
         end
         ST_ACK: begin
            // Only a low col_select ends the ack, so a held request is
            // never taken twice.
            if (!col_select) begin
               state_next = ST_IDLE;
            end
         end
`ifdef COLUMN_CLEAR_EN
         ST_CLEAR: begin
            ram_we         = 1'b1;
            ram_waddr      = clear_cnt_reg;
            ram_wdata      = CLEAR_COLOR;
            clear_cnt_next = clear_cnt_reg + ROW_W'(1);
            if (clear_cnt_reg == LAST_ROW) begin
               state_next = ST_IDLE;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   column_ram #(
      .DEPTH  (ROWS),
      .ADDR_W (ROW_W),
      .DATA_W (PIX_W)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_addr (vga_row),
      .rd_data (vga_pixel)
   );

   assign return_sig = return_reg;
   assign row_err    = row_err_reg;
`ifdef COLUMN_CLEAR_EN
   assign clear_busy = busy_reg;
`endif

endmodule

// File: tb/tb_heat_column_store.sv
module tb_heat_column_store;

   localparam int ROWS = 480;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       col_select = 1'b0;
   logic [9:0] row_select = '0;
   logic [7:0] pixel_color = '0;
   logic       return_sig;
   logic [9:0] vga_row = '0;
   logic [7:0] vga_pixel;
   logic       row_err;
`ifdef COLUMN_CLEAR_EN
   logic       clear_req = 1'b0;
   logic       clear_busy;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   always #5 clock = ~clock;

   heat_column_store dut (
      .clock       (clock),
      .reset       (reset),
      .col_select  (col_select),
      .row_select  (row_select),
      .pixel_color (pixel_color),
      .return_sig  (return_sig),
      .vga_row     (vga_row),
      .vga_pixel   (vga_pixel),
      .row_err     (row_err)
`ifdef COLUMN_CLEAR_EN
      ,
      .clear_req   (clear_req),
      .clear_busy  (clear_busy)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Protocol phases of one column, from the handshake description.
   localparam int PH_IDLE = 0, PH_PENDING = 1, PH_ACKING = 2, PH_CLEARING = 3;

   logic [7:0] m_mem   [ROWS];
   bit         m_known [ROWS];
   int         m_phase = PH_IDLE;
   int         m_row = 0;
   logic [7:0] m_pix = '0;
   int         m_clear_idx = 0;
   int         m_prev_rd = -1;
   bit         exp_ret = 0, exp_err = 0, exp_busy = 0, exp_pix_known = 1;
   logic [7:0] exp_pix = '0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_phase = PH_IDLE;
         exp_ret = 0; exp_err = 0; exp_busy = 0;
         exp_pix = '0; exp_pix_known = 1;
         m_prev_rd = -1;
      end else begin
         // Read issued one edge ago sees memory as it is before this edge's write.
         if (m_prev_rd < 0 || m_prev_rd >= ROWS) begin
            exp_pix = '0; exp_pix_known = 1;
         end else begin
            exp_pix = m_mem[m_prev_rd]; exp_pix_known = m_known[m_prev_rd];
         end
         m_prev_rd = int'(vga_row);
         if (m_phase == PH_PENDING) begin
            if (m_row < ROWS) begin
               m_mem[m_row] = m_pix; m_known[m_row] = 1;
            end else begin
               exp_err = 1;
            end
            m_phase = PH_ACKING;
         end else if (m_phase == PH_ACKING) begin
            if (!col_select) m_phase = PH_IDLE;
         end else if (m_phase == PH_CLEARING) begin
            m_mem[m_clear_idx] = 8'h00; m_known[m_clear_idx] = 1;
            m_clear_idx++;
            if (m_clear_idx == ROWS) m_phase = PH_IDLE;
         end else begin
`ifdef COLUMN_CLEAR_EN
            if (clear_req) begin
               m_phase = PH_CLEARING; m_clear_idx = 0;
            end else
`endif
            if (col_select) begin
               m_row = int'(row_select); m_pix = pixel_color; m_phase = PH_PENDING;
            end
         end
         exp_ret  = (m_phase == PH_ACKING);
         exp_busy = (m_phase == PH_CLEARING);
      end
   end

   always @(negedge clock) begin
      if (checking && !reset) begin
         check("cyc_return_sig", return_sig, exp_ret);
         check("cyc_row_err", row_err, exp_err);
         if (exp_pix_known) check("cyc_vga_pixel", vga_pixel, exp_pix);
`ifdef COLUMN_CLEAR_EN
         check("cyc_clear_busy", clear_busy, exp_busy);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic wait_ack(input string name, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (return_sig) begin ok = 1; break; end
         tick();
      end
      check({name, "_ack_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic do_write(input string name, input logic [9:0] r, input logic [7:0] p);
      col_select = 1; row_select = r; pixel_color = p;
      tick();
      wait_ack(name, 8);
      col_select = 0;
      tick();
      check({name, "_ack_drop"}, return_sig, 1'b0);
      $display("[TB] write row %0d = %02h", r, p);
   endtask

   task automatic read_row(input string name, input logic [9:0] r, input logic [7:0] exp);
      vga_row = r;
      tick(); tick();
      check(name, vga_pixel, exp);
      $display("[TB] read row %0d -> %02h", r, vga_pixel);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      check("reset_return_sig", return_sig, 1'b0);
      check("reset_row_err", row_err, 1'b0);
      check("reset_vga_pixel", vga_pixel, 8'h00);
      reset = 0;
      checking = 1;
      tick();

      // Test 1: basic write, ack timing, drop, readback
      col_select = 1; row_select = 10'd5; pixel_color = 8'hFF;
      tick(); check("t1_ret_cycle1", return_sig, 1'b0);
      tick(); check("t1_ret_cycle2", return_sig, 1'b1);
      tick(); tick(); check("t1_ret_held", return_sig, 1'b1);
      col_select = 0;
      tick(); check("t1_ret_drop", return_sig, 1'b0);
      read_row("t1_read5", 10'd5, 8'hFF);

      // Test 2: col_select held 20 cycles; data changed meanwhile must not be written
      col_select = 1; row_select = 10'd6; pixel_color = 8'h11;
      tick();
      wait_ack("t2", 8);
      pixel_color = 8'h99;
      repeat (20) tick();
      check("t2_ret_hold", return_sig, 1'b1);
      col_select = 0;
      tick();
      read_row("t2_read6", 10'd6, 8'h11);

      // Short pulse: dropped before the ack, still one write and one ack
      col_select = 1; row_select = 10'd8; pixel_color = 8'h42;
      tick(); col_select = 0;
      tick(); check("pulse_ack", return_sig, 1'b1);
      tick(); check("pulse_done", return_sig, 1'b0);
      read_row("pulse_read8", 10'd8, 8'h42);

      // Boundary: last valid row
      do_write("row479", 10'd479, 8'h5E);
      check("row479_noerr", row_err, 1'b0);
      read_row("row479_read", 10'd479, 8'h5E);

      // Test 3: out-of-range row
      do_write("t3", 10'd500, 8'hAA);
      check("t3_err", row_err, 1'b1);
      repeat (3) tick();
      check("t3_sticky", row_err, 1'b1);
      read_row("t3_read5", 10'd5, 8'hFF);
      read_row("t3_read479", 10'd479, 8'h5E);
      read_row("t3_oob_read", 10'd500, 8'h00);
      do_write("t3b", 10'd480, 8'hAB);
      read_row("t3_oob480", 10'd480, 8'h00);

      // Test 4: read-during-write returns old data
      do_write("t4a", 10'd7, 8'h11);
      vga_row = 10'd0;
      tick();
      vga_row = 10'd7; col_select = 1; row_select = 10'd7; pixel_color = 8'h3C;
      tick();
      tick(); check("t4_old", vga_pixel, 8'h11);
      tick(); check("t4_new", vga_pixel, 8'h3C);
      col_select = 0;
      tick();

      // Test 5: async reset during ack
      col_select = 1; row_select = 10'd12; pixel_color = 8'h33;
      tick();
      wait_ack("t5", 8);
      @(posedge clock); #2;
      reset = 1;
      #1;
      check("t5_ret_async", return_sig, 1'b0);
      check("t5_err_cleared", row_err, 1'b0);
      col_select = 0;
      tick(); tick();
      reset = 0;
      tick();
      read_row("t5_ram_kept", 10'd12, 8'h33);
      do_write("t5_after", 10'd13, 8'h44);
      read_row("t5_read13", 10'd13, 8'h44);

      // Short scan, checked every cycle against the model
      for (int r = 0; r < 16; r++) begin
         vga_row = 10'(r);
         tick();
      end
      tick(); tick();

`ifdef COLUMN_CLEAR_EN
      // Test 6: clear sweep with a request arriving in the same cycle
      begin
         int busy_cycles = 0;
         bit ok = 0;
         clear_req = 1; col_select = 1; row_select = 10'd9; pixel_color = 8'h5A;
         tick();
         clear_req = 0;
         for (int i = 0; i < 700; i++) begin
            if (clear_busy) busy_cycles++;
            if (return_sig) begin ok = 1; break; end
            tick();
         end
         check("t6_ack_after_clear", 32'(ok), 32'd1);
         check("t6_busy_cycles", busy_cycles, 480);
         col_select = 0;
         tick();
         $display("[TB] clear sweep busy %0d cycles", busy_cycles);
         read_row("t6_read9", 10'd9, 8'h5A);
         read_row("t6_read5", 10'd5, 8'h00);
         read_row("t6_read479", 10'd479, 8'h00);
         for (int r = 0; r < ROWS; r++) begin
            vga_row = 10'(r);
            tick();
         end
         tick(); tick();
      end
`endif

      checking = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
